halflife_decay_counter: RTL and testbench
=========================================

# halflife_decay_counter

Parametrised up/down/load counter with a built-in half-life decay mode. While decay is enabled, the held value is halved (logical shift right) once every PERIOD enabled cycles. A count of halvings applied since the last load is maintained. It is the next generation of the team's 4-bit up/down/load counter and is the core of the half-life timer datapath: software loads an initial activity and reads back the remaining value and the elapsed half-lives.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (>= 2)
- PERIOD, 16, enabled clock cycles between halvings (>= 2)
- SATURATE, 1, 1 = up/down clamp at max/0; 0 = up/down wrap modulo 2^WIDTH

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  global enable; 0 freezes all state including the prescaler
- load  in  1  load `in` into the counter
- up  in  1  increment by 1
- down  in  1  decrement by 1
- decay_en  in  1  enable periodic halving
- in  in  WIDTH  load value
- out  out  WIDTH  registered counter value
- zero  out  1  combinational, out == 0
- full  out  1  combinational, out == all ones
- halved  out  1  registered; one-cycle pulse on the cycle after a halving is applied
- halvings  out  $clog2(WIDTH+1)  registered count of halvings applied since the last load

## Operation
- Internal prescaler `pcnt` of width $clog2(PERIOD). A tick occurs at an edge where en=1, decay_en=1 and pcnt == PERIOD-1.
- Per rising edge with en=1, the following priority applies:
  1. load: out <= in, halvings <= 0, pcnt <= 0.
  2. up=1 and down=0: out <= out+1. At the all-ones value, out holds if SATURATE=1, else wraps to 0.
  3. down=1 and up=0: out <= out-1. At 0, out holds if SATURATE=1, else wraps to all ones.
  4. up=1 and down=1: out holds.
  5. Otherwise, on a tick with out != 0: out <= out >> 1, halvings <= halvings+1, halved <= 1.
- Prescaler behaviour:
  - pcnt <= 0 on a tick.
  - pcnt <= 0 whenever decay_en=0.
  - Otherwise, while decay_en=1, pcnt increments each enabled edge.
  - pcnt advances and wraps regardless of load priority, except that load clears it.
- A tick coinciding with up/down activity is lost. No halving is applied, and the next halving follows PERIOD cycles later.
- A tick with out == 0 applies nothing: no pulse and no halvings increment.
- halvings cannot exceed WIDTH, because out reaches 0 after at most WIDTH halvings. It is cleared only by load or reset.
- halved is 0 on every edge that does not apply a halving, including all edges with en=0.
- en=0: out, pcnt and halvings hold; halved <= 0.

## Timing
- Reset (rst low, asynchronous, no clock needed) sets out=0, pcnt=0, halvings=0, halved=0. Consequently zero=1 and full=0. Reset asserted mid-decay aborts the decay immediately. Deassertion is sampled at the next rising edge.
- Load, up and down take effect at the edge where they are sampled, so the new out is visible after 1 cycle.
- Load at edge k with decay_en held at 1 and en=1: halvings occur at edges k+PERIOD, k+2·PERIOD, and so on. halved is high during the cycle following each of those edges.
- Each en=0 cycle postpones the next tick by exactly one cycle.
- Raising decay_en at edge j (pcnt=0) gives the first halving at edge j+PERIOD.
- zero and full follow out combinationally, with zero added cycles.

## Test plan
- Reset: load 8'hA5, then pull rst low between edges. out=0, halvings=0 and halved=0 immediately, without a clock edge. After release with all controls low, out stays 0.
- Decay chain (WIDTH=8, PERIOD=4): load 200 with decay_en=1. out steps 200→100→50→25→12→6→3→1→0 at 4-cycle intervals. halved pulses 8 times; halvings ends at 8. zero=1 afterwards, with no further pulses over 20 more cycles.
- Clamp and wrap:
  - SATURATE=1: load 255 then up gives 255 with full=1; load 0 then down gives 0.
  - SATURATE=0: 255 up gives 0; 0 down gives 255.
- Priority: load=up=down=1 with in=7 gives out=7. up=down=1 holds. Asserting up on a tick edge during decay from 64 gives 65 with no halved pulse; the next halving gives 32 exactly PERIOD cycles later.
- Enable freeze: during decay (PERIOD=4), drop en for 3 cycles mid-period. out, halvings and pcnt hold, halved=0, and the next halving arrives 3 cycles late.
- Decay gating: toggle decay_en low for 2 cycles at pcnt=2. The prescaler clears, and the next halving occurs PERIOD cycles after decay_en returns high.

Source files
------------

// File: rtl/halflife_decay_counter.sv
// Up/down/load counter with a periodic half-life decay mode.
// A prescaler paces the halvings; halvings counts them since the last load.
module halflife_decay_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PERIOD   = 16,
    parameter bit          SATURATE = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       load,
    input  logic                       up,
    input  logic                       down,
    input  logic                       decay_en,
    input  logic [WIDTH-1:0]           in,
    output logic [WIDTH-1:0]           out,
    output logic                       zero,
    output logic                       full,
    output logic                       halved,
    output logic [$clog2(WIDTH+1)-1:0] halvings
);

    localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned HW = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0] MaxVal  = {WIDTH{1'b1}};
    localparam logic [PW-1:0]    LastCnt = PW'(PERIOD - 1);

    logic [WIDTH-1:0] out_q, out_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [HW-1:0]    hv_q, hv_d;
    logic             halved_q, halved_d;
    logic             tick;

    assign tick = en && decay_en && (pcnt_q == LastCnt);

    always_comb begin
        out_d    = out_q;
        pcnt_d   = pcnt_q;
        hv_d     = hv_q;
        halved_d = 1'b0;

        if (en) begin
            // Prescaler runs independently of the counter priority; only load clears it early.
            if (!decay_en || tick) begin
                pcnt_d = '0;
            end else begin
                pcnt_d = pcnt_q + PW'(1);
            end

            if (load) begin
                out_d  = in;
                hv_d   = '0;
                pcnt_d = '0;
            end else if (up && !down) begin
                if (!(SATURATE && (out_q == MaxVal))) begin
                    out_d = out_q + WIDTH'(1);
                end
            end else if (down && !up) begin
                if (!(SATURATE && (out_q == '0))) begin
                    out_d = out_q - WIDTH'(1);
                end
            end else if (!up && !down && tick && (out_q != '0)) begin
                // up&&down holds and also swallows any coinciding tick.
                out_d    = out_q >> 1;
                hv_d     = hv_q + HW'(1);
                halved_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q    <= '0;
            pcnt_q   <= '0;
            hv_q     <= '0;
            halved_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            pcnt_q   <= pcnt_d;
            hv_q     <= hv_d;
            halved_q <= halved_d;
        end
    end

    assign out      = out_q;
    assign halved   = halved_q;
    assign halvings = hv_q;
    assign zero     = (out_q == '0);
    assign full     = (out_q == MaxVal);

endmodule

// File: tb/tb_halflife_decay_counter.sv
// Bench for halflife_decay_counter: saturating and wrapping instances side by side,
// checked every cycle against an integer reference model.
module tb_halflife_decay_counter;

    localparam int W = 8;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, load = 1'b0, up = 1'b0, down = 1'b0, decay_en = 1'b0;
    logic [7:0] din = 8'd0;

    logic [7:0] out_s, out_w;
    logic       zero_s, zero_w, full_s, full_w, halved_s, halved_w;
    logic [3:0] hv_s, hv_w;

    int total = 0;
    int bad = 0;

    // Reference model state: index 1 = saturating, index 0 = wrapping.
    int m_out[2];
    int m_h[2];
    int m_pulse[2];
    int m_cnt;

    always #5 clk = ~clk;

    halflife_decay_counter #(.WIDTH(W), .PERIOD(P), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .load(load), .up(up), .down(down),
        .decay_en(decay_en), .in(din), .out(out_s), .zero(zero_s), .full(full_s),
        .halved(halved_s), .halvings(hv_s)
    );

    halflife_decay_counter #(.WIDTH(W), .PERIOD(P), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .en(en), .load(load), .up(up), .down(down),
        .decay_en(decay_en), .in(din), .out(out_w), .zero(zero_w), .full(full_w),
        .halved(halved_w), .halvings(hv_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_out[s]   = 0;
            m_h[s]     = 0;
            m_pulse[s] = 0;
        end
        m_cnt = 0;
    endtask

    task automatic model_edge();
        bit tick;
        if (!en) begin
            m_pulse[0] = 0;
            m_pulse[1] = 0;
            return;
        end
        tick = decay_en && (m_cnt == P - 1);
        if (load || !decay_en || tick) m_cnt = 0;
        else m_cnt = m_cnt + 1;
        for (int s = 0; s < 2; s++) begin
            m_pulse[s] = 0;
            if (load) begin
                m_out[s] = int'(din);
                m_h[s]   = 0;
            end else if (up && !down) begin
                if (s == 1) m_out[s] = (m_out[s] == 255) ? 255 : m_out[s] + 1;
                else        m_out[s] = (m_out[s] + 1) % 256;
            end else if (down && !up) begin
                if (s == 1) m_out[s] = (m_out[s] == 0) ? 0 : m_out[s] - 1;
                else        m_out[s] = (m_out[s] + 255) % 256;
            end else if (!up && !down && tick && m_out[s] != 0) begin
                m_out[s]   = m_out[s] / 2;
                m_h[s]     = m_h[s] + 1;
                m_pulse[s] = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/sat/out"},      32'(out_s),    32'(m_out[1]));
        chk({tag, "/sat/zero"},     32'(zero_s),   32'(m_out[1] == 0));
        chk({tag, "/sat/full"},     32'(full_s),   32'(m_out[1] == 255));
        chk({tag, "/sat/halved"},   32'(halved_s), 32'(m_pulse[1]));
        chk({tag, "/sat/halvings"}, 32'(hv_s),     32'(m_h[1]));
        chk({tag, "/wrap/out"},      32'(out_w),    32'(m_out[0]));
        chk({tag, "/wrap/zero"},     32'(zero_w),   32'(m_out[0] == 0));
        chk({tag, "/wrap/full"},     32'(full_w),   32'(m_out[0] == 255));
        chk({tag, "/wrap/halved"},   32'(halved_w), 32'(m_pulse[0]));
        chk({tag, "/wrap/halvings"}, 32'(hv_w),     32'(m_h[0]));
    endtask

    task automatic drive(input bit e, input bit l, input bit u, input bit d, input bit de,
                         input logic [7:0] v);
        en = e; load = l; up = u; down = d; decay_en = de; din = v;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        int npulse;
        // Power-on reset
        model_reset();
        #3;
        check_all("por");
        #4 rst = 1'b1;

        // Asynchronous reset between edges
        drive(1, 1, 0, 0, 0, 8'hA5);
        cycle("load_a5");
        drive(1, 0, 0, 0, 0, 8'h00);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #3 rst = 1'b1;
        repeat (3) cycle("post_rst");

        // Decay chain from 200
        drive(1, 1, 0, 0, 1, 8'd200);
        cycle("chain_load");
        drive(1, 0, 0, 0, 1, 8'd0);
        npulse = 0;
        for (int i = 0; i < 8 * P + 20; i++) begin
            cycle("chain");
            if (halved_s) npulse++;
        end
        chk("chain_pulses", 32'(npulse), 32'd8);
        chk("chain_final_out", 32'(out_s), 32'd0);
        chk("chain_final_halvings", 32'(hv_s), 32'd8);
        chk("chain_final_zero", 32'(zero_s), 32'd1);

        // Clamp and wrap
        drive(1, 1, 0, 0, 0, 8'd255);
        cycle("ld255");
        drive(1, 0, 1, 0, 0, 8'd0);
        cycle("up_at_max");
        drive(1, 1, 0, 0, 0, 8'd0);
        cycle("ld0");
        drive(1, 0, 0, 1, 0, 8'd0);
        cycle("down_at_0");

        // Priority
        drive(1, 1, 1, 1, 0, 8'd7);
        cycle("load_wins");
        drive(1, 0, 1, 1, 0, 8'd0);
        cycle("updown_hold");

        // Up on a tick edge loses the halving
        drive(1, 1, 0, 0, 1, 8'd64);
        cycle("ld64");
        drive(1, 0, 0, 0, 1, 8'd0);
        repeat (P - 1) cycle("pre_tick");
        drive(1, 0, 1, 0, 1, 8'd0);
        cycle("up_on_tick");
        drive(1, 0, 0, 0, 1, 8'd0);
        repeat (P + 1) cycle("after_lost_tick");

        // Enable freeze mid-period
        drive(1, 1, 0, 0, 1, 8'd128);
        cycle("ld128");
        drive(1, 0, 0, 0, 1, 8'd0);
        repeat (2) cycle("freeze_pre");
        drive(0, 0, 0, 0, 1, 8'd0);
        repeat (3) cycle("frozen");
        drive(1, 0, 0, 0, 1, 8'd0);
        repeat (2 * P) cycle("freeze_post");

        // Decay gating at pcnt=2
        drive(1, 1, 0, 0, 1, 8'd100);
        cycle("ld100");
        drive(1, 0, 0, 0, 1, 8'd0);
        repeat (2) cycle("gate_pre");
        drive(1, 0, 0, 0, 0, 8'd0);
        repeat (2) cycle("gated");
        drive(1, 0, 0, 0, 1, 8'd0);
        repeat (2 * P) cycle("gate_post");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 90, $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 8,
                  $urandom_range(0, 99) < 92, 8'($urandom));
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
